// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Controller-side bundle for the iterative divider.
//                Carries the start/sign/annul controls and both operands
//                into the divider, and the {HI,LO} result, the ready pulse
//                and the stall request back out.
//                  master : controller / pipeline side (drives the controls)
//                  slave  : divider side
//  Revision    : 1.0  initial release
// ============================================================================
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 sign;
  logic                 annul;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 stall;

  modport master (
    output start, sign, annul, opdata1, opdata2,
    input  result, ready, stall
  );

  modport slave (
    input  start, sign, annul, opdata1, opdata2,
    output result, ready, stall
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-2 restoring divider for DIV / DIVU.
//                One quotient bit per cycle, WIDTH cycles per division, plus
//                a fast path for a zero divisor.
//  Ports       : clk     - clock, rising edge
//                rst     - synchronous active-high reset
//                bus_if  - div_unit_if.slave
//                  start   : begin a division (sampled in IDLE only)
//                  sign    : 1 = signed (DIV), 0 = unsigned (DIVU)
//                  annul   : cancel the division in progress
//                  opdata1 : dividend
//                  opdata2 : divisor
//                  result  : {remainder, quotient}, held until next load
//                  ready   : one-cycle pulse, result valid
//                  stall   : combinational pipeline freeze request
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus_if
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_DIVZERO = 2'd1;
  localparam logic [1:0] c_ON      = 2'd2;
  localparam logic [1:0] c_END     = 2'd3;

  localparam logic [CW-1:0] c_LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]           state_q,     state_d;
  logic                 sign_mode_q, sign_mode_d;
  logic                 neg1_q,      neg1_d;
  logic                 neg2_q,      neg2_d;
  logic [WIDTH-1:0]     divisor_q,   divisor_d;
  logic [WIDTH-1:0]     raw1_q,      raw1_d;
  logic [CW-1:0]        cnt_q,       cnt_d;
  logic [2*WIDTH:0]     pr_q,        pr_d;
  logic [2*WIDTH-1:0]   result_q,    result_d;

  // Operand magnitudes; sign bits only matter in signed mode.
  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;

  assign w_neg1 = bus_if.sign & bus_if.opdata1[WIDTH-1];
  assign w_neg2 = bus_if.sign & bus_if.opdata2[WIDTH-1];
  assign w_abs1 = w_neg1 ? -bus_if.opdata1 : bus_if.opdata1;
  assign w_abs2 = w_neg2 ? -bus_if.opdata2 : bus_if.opdata2;

  // One restoring step. The upper half of the shifted remainder is taken
  // with the bit that falls off the top included (always 0, since a kept
  // trial result is never negative), which gives a spare sign bit for the
  // trial subtraction.
  logic [WIDTH+1:0] w_trial;
  logic [2*WIDTH:0] w_pr_step;

  assign w_trial   = pr_q[2*WIDTH:WIDTH-1] - {2'b00, divisor_q};
  assign w_pr_step = w_trial[WIDTH+1]
                   ? {pr_q[2*WIDTH-1:0], 1'b0}
                   : {w_trial[WIDTH:0], pr_q[WIDTH-2:0], 1'b1};

  // Sign fixup applied to the values produced by the final step.
  logic [WIDTH-1:0] w_q_raw;
  logic [WIDTH-1:0] w_r_raw;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_q_raw = w_pr_step[WIDTH-1:0];
  assign w_r_raw = w_pr_step[2*WIDTH-1:WIDTH];
  assign w_q_fix = (sign_mode_q & (neg1_q ^ neg2_q)) ? -w_q_raw : w_q_raw;
  assign w_r_fix = (sign_mode_q & neg1_q)            ? -w_r_raw : w_r_raw;

  always_comb begin
    state_d     = state_q;
    sign_mode_d = sign_mode_q;
    neg1_d      = neg1_q;
    neg2_d      = neg2_q;
    divisor_d   = divisor_q;
    raw1_d      = raw1_q;
    cnt_d       = cnt_q;
    pr_d        = pr_q;
    result_d    = result_q;

    case (state_q)
      c_IDLE: begin
        if (bus_if.start && !bus_if.annul) begin
          sign_mode_d = bus_if.sign;
          neg1_d      = w_neg1;
          neg2_d      = w_neg2;
          divisor_d   = w_abs2;
          raw1_d      = bus_if.opdata1;
          cnt_d       = '0;
          pr_d        = {{(WIDTH+1){1'b0}}, w_abs1};
          state_d     = (bus_if.opdata2 == '0) ? c_DIVZERO : c_ON;
        end
      end

      c_DIVZERO: begin
        if (bus_if.annul) begin
          state_d = c_IDLE;
        end else begin
          // Remainder is the untouched dividend, no sign fixup.
          result_d = {raw1_q, {WIDTH{1'b1}}};
          state_d  = c_END;
        end
      end

      c_ON: begin
        if (bus_if.annul) begin
          state_d = c_IDLE;
        end else begin
          pr_d  = w_pr_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == c_LAST_STEP) begin
            result_d = {w_r_fix, w_q_fix};
            state_d  = c_END;
          end
        end
      end

      c_END: begin
        state_d = c_IDLE;
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_IDLE;
      sign_mode_q <= 1'b0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      divisor_q   <= '0;
      raw1_q      <= '0;
      cnt_q       <= '0;
      pr_q        <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      sign_mode_q <= sign_mode_d;
      neg1_q      <= neg1_d;
      neg2_q      <= neg2_d;
      divisor_q   <= divisor_d;
      raw1_q      <= raw1_d;
      cnt_q       <= cnt_d;
      pr_q        <= pr_d;
      result_q    <= result_d;
    end
  end

  assign bus_if.result = result_q;
  assign bus_if.ready  = (state_q == c_END);
  assign bus_if.stall  = bus_if.start & ~bus_if.ready & ~bus_if.annul;

endmodule
`default_nettype wire
